// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: handshake bundle between N byte-stream requesters, the
// round-robin arbiter and the UART TX serializer.
//   req_valid_i/req_data_i/req_last_i : requester bytes (requester k uses
//                                       req_data_i[8k+7:8k])
//   req_ready_o                       : per-requester accept
//   tx_valid_o/tx_data_o/tx_ready_i   : registered stream to the serializer
//   grant_o/busy_o/timeout_o          : arbitration status
// modport master: requester/serializer side; modport slave: the arbiter.
interface uart_tx_arb_if #(
  parameter int unsigned N = 2
);
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic           tx_valid_o;
  logic [7:0]     tx_data_o;
  logic           tx_ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART TX path between N
// requesters. A grant lasts a whole message (through the byte flagged
// last); a stalled owner loses the grant after TIMEOUT idle cycles.
// Ports:
//   clk_i    : system clock
//   arst_n_i : asynchronous active-low reset
//   bus      : uart_tx_arb_if.slave (requester handshakes, registered
//              serializer output, grant/busy/timeout status)
module uart_tx_arb #(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CW      = 16
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  uart_tx_arb_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, GNT} state_e;

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic          busy_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          timeout_q;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  int unsigned   cand;
  logic          out_free;
  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;
  logic          xfer;
  logic [N-1:0]  ready;

  // Search upward from rr_ptr+1 (mod N); the first valid requester wins,
  // so the previous owner is considered last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(rr_ptr_q) + 32'd1 + i) % N;
      if (!pick_valid && bus.req_valid_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  assign out_free  = !tx_valid_q || bus.tx_ready_i;
  assign own_valid = bus.req_valid_i[owner_q];
  assign own_last  = bus.req_last_i[owner_q];
  assign own_data  = bus.req_data_i[32'(owner_q) * 8 +: 8];
  assign xfer      = (state_q == GNT) && own_valid && out_free;

  always_comb begin
    ready = '0;
    if (state_q == GNT) ready = grant_q & {N{out_free}};
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= IW'(N - 1);
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;

      // Output register drains regardless of state; a load in the same
      // cycle as a drain keeps valid high for back-to-back bytes.
      if (xfer) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= own_data;
      end else if (bus.tx_ready_i) begin
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_valid) begin
            state_q <= GNT;
            owner_q <= pick_idx;
            grant_q <= N'(1) << pick_idx;
            busy_q  <= 1'b1;
          end
        end
        GNT: begin
          if (xfer) begin
            cnt_q <= '0;
            if (own_last) begin
              rr_ptr_q <= owner_q;
              state_q  <= IDLE;
              grant_q  <= '0;
              busy_q   <= 1'b0;
            end
          end else if (!own_valid && (TIMEOUT != 0)) begin
            // Only an absent owner counts; backpressure never does.
            if (cnt_q == TO_LAST) begin
              timeout_q <= 1'b1;
              rr_ptr_q  <= owner_q;
              state_q   <= IDLE;
              grant_q   <= '0;
              busy_q    <= 1'b0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb with N=3, TIMEOUT=8.
module tb_uart_tx_arb;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_errors;

  uart_tx_arb_if #(.N(3)) bus ();

  uart_tx_arb #(.N(3), .TIMEOUT(8), .CW(16)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid_i[k]        = v;
    bus.req_data_i[8*k +: 8]  = d;
    bus.req_last_i[k]         = l;
  endtask

  task automatic clear_reqs();
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #3;
    arst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int            idx [3];
  logic [7:0]    got_b [8];
  logic [2:0]    got_g [4];
  logic [7:0]    exp_b [8];
  logic [2:0]    exp_g [4];
  int            nb, ng;
  logic [2:0]    prev_g, acc;

  initial begin
    n_checks = 0;
    n_errors = 0;
    arst_n   = 1'b0;
    clear_reqs();
    bus.tx_ready_i = 1'b1;

    // Reset state
    cyc(); cyc();
    check("rst_tx_valid", 32'(bus.tx_valid_o), 0);
    check("rst_tx_data",  32'(bus.tx_data_o), 0);
    check("rst_grant",    32'(bus.grant_o), 0);
    check("rst_busy",     32'(bus.busy_o), 0);
    check("rst_timeout",  32'(bus.timeout_o), 0);
    check("rst_ready",    32'(bus.req_ready_o), 0);
    arst_n = 1'b1;

    // Single message from requester 0
    set_req(0, 1'b1, 8'h41, 1'b0);
    #1;
    check("idle_ready", 32'(bus.req_ready_o), 0);
    cyc();
    check("sm_grant", 32'(bus.grant_o), 32'b001);
    check("sm_busy",  32'(bus.busy_o), 1);
    check("sm_ready", 32'(bus.req_ready_o), 32'b001);
    cyc();
    check("sm_b0_valid", 32'(bus.tx_valid_o), 1);
    check("sm_b0", 32'(bus.tx_data_o), 32'h41);
    set_req(0, 1'b1, 8'h42, 1'b0);
    cyc();
    check("sm_b1", 32'(bus.tx_data_o), 32'h42);
    set_req(0, 1'b1, 8'h43, 1'b1);
    cyc();
    check("sm_b2", 32'(bus.tx_data_o), 32'h43);
    check("sm_b2_valid", 32'(bus.tx_valid_o), 1);
    check("sm_end_busy", 32'(bus.busy_o), 0);
    check("sm_end_grant", 32'(bus.grant_o), 0);
    clear_reqs();
    cyc();
    check("sm_drain", 32'(bus.tx_valid_o), 0);

    // Round-robin: all three valid, 2-byte messages
    do_reset();
    exp_b = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h12, 8'h13};
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int k = 0; k < 3; k++) idx[k] = 0;
    for (int k = 0; k < 8; k++) got_b[k] = '0;
    for (int k = 0; k < 4; k++) got_g[k] = '0;
    nb = 0; ng = 0; prev_g = '0;
    for (int c = 0; c < 60 && nb < 8; c++) begin
      for (int k = 0; k < 3; k++)
        set_req(k, 1'b1, 8'((k + 1) * 16 + idx[k]), (idx[k] % 2) == 1);
      #1;
      acc = bus.req_valid_i & bus.req_ready_o;
      cyc();
      for (int k = 0; k < 3; k++) if (acc[k]) idx[k]++;
      if (bus.grant_o != 0 && bus.grant_o != prev_g && ng < 4) begin
        got_g[ng] = bus.grant_o;
        ng++;
      end
      prev_g = bus.grant_o;
      if (bus.tx_valid_o && nb < 8) begin
        got_b[nb] = bus.tx_data_o;
        nb++;
      end
    end
    clear_reqs();
    for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), 32'(got_g[k]), 32'(exp_g[k]));
    for (int k = 0; k < 8; k++) check($sformatf("rr_byte%0d", k), 32'(got_b[k]), 32'(exp_b[k]));
    cyc();
    check("rr_idle_grant", 32'(bus.grant_o), 0);
    check("rr_drain", 32'(bus.tx_valid_o), 0);

    // Backpressure on requester 1 (last owner was 0)
    set_req(1, 1'b1, 8'h55, 1'b0);
    cyc();
    check("bp_grant", 32'(bus.grant_o), 32'b010);
    cyc();
    check("bp_load", 32'(bus.tx_data_o), 32'h55);
    bus.tx_ready_i = 1'b0;
    set_req(1, 1'b1, 8'h66, 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_ready", 32'(bus.req_ready_o), 0);
      check("bp_hold", 32'(bus.tx_data_o), 32'h55);
      check("bp_valid", 32'(bus.tx_valid_o), 1);
      cyc();
      check("bp_no_timeout", 32'(bus.timeout_o), 0);
    end
    check("bp_still_granted", 32'(bus.grant_o), 32'b010);
    bus.tx_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready_o), 32'b010);
    check("bp_release_data", 32'(bus.tx_data_o), 32'h55);
    cyc();
    // simultaneous drain of 0x55 and load of 0x66
    check("dl_valid", 32'(bus.tx_valid_o), 1);
    check("dl_data", 32'(bus.tx_data_o), 32'h66);
    check("dl_busy", 32'(bus.busy_o), 0);
    clear_reqs();
    cyc();
    check("bp_drain", 32'(bus.tx_valid_o), 0);

    // Timeout: requester 1 sends a non-last byte then goes silent
    set_req(1, 1'b1, 8'h77, 1'b0);
    cyc();
    check("to_grant", 32'(bus.grant_o), 32'b010);
    cyc();
    check("to_load", 32'(bus.tx_data_o), 32'h77);
    set_req(1, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h99, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      check("to_wait_ready0", 32'(bus.req_ready_o[0]), 0);
      cyc();
      check($sformatf("to_pulse_c%0d", c), 32'(bus.timeout_o), (c == 8) ? 1 : 0);
      check($sformatf("to_busy_c%0d", c), 32'(bus.busy_o), (c == 8) ? 0 : 1);
    end
    cyc();
    check("to_pulse_end", 32'(bus.timeout_o), 0);
    check("to_next_grant", 32'(bus.grant_o), 32'b001);

    // Async reset mid-message with a byte held in the output register
    set_req(0, 1'b1, 8'h88, 1'b0);
    bus.tx_ready_i = 1'b0;
    cyc();
    check("ar_load", 32'(bus.tx_data_o), 32'h88);
    check("ar_load_valid", 32'(bus.tx_valid_o), 1);
    #3;
    arst_n = 1'b0;
    #1;
    check("ar_tx_valid", 32'(bus.tx_valid_o), 0);
    check("ar_tx_data", 32'(bus.tx_data_o), 0);
    check("ar_grant", 32'(bus.grant_o), 0);
    check("ar_busy", 32'(bus.busy_o), 0);
    bus.tx_ready_i = 1'b1;
    set_req(0, 1'b1, 8'hA0, 1'b1);
    set_req(1, 1'b1, 8'hA1, 1'b1);
    set_req(2, 1'b1, 8'hA2, 1'b1);
    #2;
    arst_n = 1'b1;
    cyc();
    check("ar_first_grant", 32'(bus.grant_o), 32'b001);
    clear_reqs();
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
